// File: rtl/audio_capture.sv
// audio_capture: arm/trigger frame recorder for the codec sample stream.
// Waits for arm, triggers on the first sample with |ain| >= THRESH, stores DEPTH words
// into a block RAM and holds the frame until clear. Synchronous one-cycle read port.
// Optional macro DECIM_EN: 2:1 decimation, one stored word per pair of accepted samples.
module audio_capture #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned AW     = 12,
    parameter logic [15:0] THRESH = 16'd2000
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic [15:0]   ain,
    input  logic          ain_new,
    input  logic          arm,
    input  logic          clear,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic [15:0]   peak
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArmed   = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic [AW:0] FullCount = DEPTH[AW:0];

    logic [1:0]  state_q, state_d;
    logic [AW:0] count_q, count_d;
    logic [15:0] peak_q, peak_d;
    logic [15:0] rd_data_q;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] ain_abs;

    logic [15:0] mem [DEPTH];

    // Absolute value with -32768 saturating to 32767.
    function automatic logic [15:0] abs16(input logic [15:0] x);
        if (x == 16'h8000) begin
            return 16'h7fff;
        end else if (x[15]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    assign ain_abs = abs16(ain);

`ifdef DECIM_EN
    logic [15:0]        first_q, first_d;
    logic               pend_q, pend_d;
    logic signed [16:0] pair_sum;

    assign pair_sum = $signed({first_q[15], first_q}) + $signed({ain[15], ain});

    // Holds the first sample of a pair until its partner arrives.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            first_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            first_q <= first_d;
            pend_q  <= pend_d;
        end
    end
`endif

    // Next-state, write enable and write data.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        peak_d  = peak_q;
        we      = 1'b0;
        wdata   = ain;
`ifdef DECIM_EN
        first_d = first_q;
        pend_d  = pend_q;
`endif
        if (clear) begin
            state_d = StIdle;
            count_d = '0;
`ifdef DECIM_EN
            pend_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        state_d = StArmed;
                        count_d = '0;
                        peak_d  = '0;
                    end
                end
                StArmed: begin
                    if (ain_new && (ain_abs >= THRESH)) begin
                        state_d = StCapture;
`ifdef DECIM_EN
                        first_d = ain;
                        pend_d  = 1'b1;
`else
                        we      = 1'b1;
`endif
                    end
                end
                StCapture: begin
                    if (ain_new) begin
`ifdef DECIM_EN
                        if (!pend_q) begin
                            first_d = ain;
                            pend_d  = 1'b1;
                        end else begin
                            we      = 1'b1;
                            wdata   = pair_sum[16:1];
                            pend_d  = 1'b0;
                        end
`else
                        we = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
            if (we) begin
                count_d = count_q + 1'b1;
                if (abs16(wdata) > peak_q) begin
                    peak_d = abs16(wdata);
                end
                if (count_d == FullCount) begin
                    state_d = StDone;
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
            peak_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            peak_q  <= peak_d;
        end
    end

    // RAM write port; no reset so it maps onto block RAM.
    always_ff @(posedge CLOCK_50) begin
        if (we) begin
            mem[count_q[AW-1:0]] <= wdata;
        end
    end

    // Synchronous read port; same-address read during a write returns the old word.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = (state_q == StArmed) || (state_q == StCapture);
    assign done    = (state_q == StDone);
    assign count   = count_q;
    assign peak    = peak_q;

endmodule

// File: tb/tb_audio_capture.sv
// Bench for audio_capture: directed scenarios then random traffic, checked against a
// frame-level model (captured words kept as a queue). Honours DECIM_EN if defined.
module tb_audio_capture;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;
    localparam logic [15:0] THRESH = 16'd2000;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b1;
    logic [15:0]   ain      = '0;
    logic          ain_new  = 1'b0;
    logic          arm      = 1'b0;
    logic          clear    = 1'b0;
    logic [AW-1:0] rd_addr  = '0;
    logic [15:0]   rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic [15:0]   peak;

    int n_checks = 0;
    int n_fail   = 0;

    audio_capture #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .THRESH (THRESH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .ain      (ain),
        .ain_new  (ain_new),
        .arm      (arm),
        .clear    (clear),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .peak     (peak)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model: mode 0 idle, 1 armed, 2 capturing, 3 frame held.
    int          m_mode = 0;
    logic [15:0] m_frame[$];
    logic [15:0] m_mem[DEPTH];
    bit          m_memv[DEPTH];
    int          m_peak = 0;
    bit          m_pend = 0;
    int          m_first = 0;
    logic [15:0] exp_rd = '0;
    bit          exp_rd_v = 0;

    function automatic int absv(input logic [15:0] x);
        int v;
        v = $signed(x);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_store(input logic [15:0] w);
        int idx;
        idx = m_frame.size();
        m_mem[idx]  = w;
        m_memv[idx] = 1;
        m_frame.push_back(w);
        if (absv(w) > m_peak) m_peak = absv(w);
        if (m_frame.size() == DEPTH) m_mode = 3;
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_frame.delete();
        m_peak = 0;
        m_pend = 0;
        for (int i = 0; i < DEPTH; i++) m_memv[i] = 0;
        exp_rd_v = 0;
    endtask

    // Applies the current inputs to the model as of the coming rising edge.
    task automatic model_edge();
        exp_rd_v = m_memv[rd_addr];
        exp_rd   = m_mem[rd_addr];
        if (clear) begin
            m_mode = 0;
            m_frame.delete();
            m_pend = 0;
        end else if (m_mode == 0) begin
            if (arm) begin
                m_mode = 1;
                m_frame.delete();
                m_peak = 0;
            end
        end else if (m_mode == 1) begin
            if (ain_new && absv(ain) >= int'(THRESH)) begin
                m_mode = 2;
`ifdef DECIM_EN
                m_first = $signed(ain);
                m_pend  = 1;
`else
                model_store(ain);
`endif
            end
        end else if (m_mode == 2) begin
            if (ain_new) begin
`ifdef DECIM_EN
                if (!m_pend) begin
                    m_first = $signed(ain);
                    m_pend  = 1;
                end else begin
                    int s;
                    s = m_first + int'($signed(ain));
                    model_store(16'(s >>> 1));
                    m_pend = 0;
                end
`else
                model_store(ain);
`endif
            end
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(m_frame.size()));
        chk("busy", 32'(busy), 32'((m_mode == 1) || (m_mode == 2)));
        chk("done", 32'(done), 32'(m_mode == 3));
        chk("peak", 32'(peak), 32'(m_peak));
        if (exp_rd_v) chk("rd_data", 32'(rd_data), 32'(exp_rd));
    endtask

    task automatic step(input bit a, input bit c, input bit n, input logic [15:0] s);
        arm     = a;
        clear   = c;
        ain_new = n;
        ain     = s;
        model_edge();
        @(posedge CLOCK_50);
        #1;
        arm     = 1'b0;
        clear   = 1'b0;
        ain_new = 1'b0;
        check_all();
    endtask

    initial begin
        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_peak", 32'(peak), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        model_reset();
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        // 1: arm, sub-threshold samples, then trigger
        step(1, 0, 0, 16'd0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 16'd100);
        step(0, 0, 1, 16'd2500);
`ifndef DECIM_EN
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        rd_addr = '0;
        step(0, 0, 0, 16'd0);
        chk("t1_rd0", 32'(rd_data), 32'd2500);

        // 2: fill the frame, extras ignored
        for (int i = 1; i <= 15; i++) begin
            step(0, 0, 1, 16'(i));
            if (i == 14) chk("t2_notdone", 32'(done), 32'd0);
        end
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_count", 32'(count), 32'd16);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'd3000 + 16'(i));
        rd_addr = 4'd15;
        step(0, 0, 0, 16'd0);
        chk("t2_rd15", 32'(rd_data), 32'd15);
        chk("t2_peak", 32'(peak), 32'd2500);

        // 3: trigger on most-negative sample
        step(0, 1, 0, 16'd0);
        step(1, 0, 0, 16'd0);
        step(0, 0, 1, 16'h8000);
        rd_addr = '0;
        step(0, 0, 0, 16'd0);
        chk("t3_rd0", 32'(rd_data), 32'h8000);
        chk("t3_peak", 32'(peak), 32'd32767);
`else
        // 6: decimated pairs
        step(0, 1, 0, 16'd0);
        step(1, 0, 0, 16'd0);
        step(0, 0, 1, 16'd3000);
        step(0, 0, 1, 16'd1001);
        chk("t6_count", 32'(count), 32'd1);
        chk("t6_peak", 32'(peak), 32'd2000);
        rd_addr = '0;
        step(0, 0, 0, 16'd0);
        chk("t6_rd0", 32'(rd_data), 32'd2000);
        step(0, 0, 1, 16'hfffd);
        step(0, 0, 1, 16'hfffc);
        rd_addr = 4'd1;
        step(0, 0, 0, 16'd0);
        chk("t6_rd1", 32'(rd_data), 32'hfffc);
`endif

        // 4: clear and arm together while a frame is held
        step(0, 1, 0, 16'd0);
        step(1, 0, 0, 16'd0);
        step(0, 0, 1, 16'd3000);
        for (int i = 0; i < 4 * DEPTH && m_mode != 3; i++) step(0, 0, 1, 16'($urandom));
        chk("t4_done_before", 32'(done), 32'd1);
        step(1, 1, 0, 16'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // 5: asynchronous reset mid-capture
        step(1, 0, 0, 16'd0);
        step(0, 0, 1, 16'hf000);
        for (int i = 0; i < 4 * DEPTH && m_frame.size() < 7; i++) step(0, 0, 1, 16'($urandom));
        chk("t5_count7", 32'(count), 32'd7);
        #4 reset_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_peak", 32'(peak), 32'd0);
        chk("t5_rd", 32'(rd_data), 32'd0);
        model_reset();
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        step(0, 0, 1, 16'd5000);
        chk("t5_nowrite", 32'(count), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] s;
            s = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                            : 16'($urandom_range(0, 1999));
            rd_addr = AW'($urandom);
            step($urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 1) == 1, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
